rgb_block_planarizer: RTL and testbench

Upstream feeder for the JPEG core. Accepts interleaved 24-bit RGB pixels, one per beat, in 8x8 raster order. Buffers each 64-pixel block in a ping-pong store and re-emits it as three planar AXI-Stream bursts (R, then G, then B), which is the format the JPEG core input expects: 16 words per plane, 4 pixels per 32-bit word, tlast on the last word of each plane. Ping-pong lets the next block fill while the current one drains.

---
 rtl/rgb_block_planarizer.sv | 166 ++++++++++++++++
 tb/tb_rgb_block_planarizer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_block_planarizer.sv
// Buffers 8x8 blocks of interleaved RGB pixels in a ping-pong store and
// re-emits each block as three planar AXI-Stream bursts (R, G, B).
module rgb_block_planarizer #(
    parameter int unsigned DATA_DEPTH             = 8,
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                  axis_aclk,
    input  logic                                  axis_areset,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic                                  s00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tlast,
    output logic                                  tlast_err
);

    localparam int unsigned PX_W        = 24;
    localparam int unsigned N_PIX       = DATA_DEPTH * DATA_DEPTH;
    localparam int unsigned CNT_W       = $clog2(N_PIX);
    localparam int unsigned PX_PER_WORD = C_M00_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned N_WORDS     = N_PIX / PX_PER_WORD;
    localparam int unsigned K_W         = $clog2(N_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLANE_R = 2'd1,
        PLANE_G = 2'd2,
        PLANE_B = 2'd3
    } rd_state_t;

    logic [PX_W-1:0]  mem [2][N_PIX];
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] wr_cnt;
    rd_state_t        state;
    logic [K_W-1:0]   k;

    logic                              wr_fire_c;
    logic                              wr_last_c;
    logic                              wr_done_c;
    logic                              out_ld_c;
    logic                              k_last_c;
    logic                              rd_free_c;
    logic [1:0]                        full_nxt_c;
    logic                              wr_bank_nxt_c;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] rd_word_c;
    logic                              unused_tdata_c;

    // Upper input byte carries no pixel information.
    assign unused_tdata_c = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:PX_W];

    assign m00_axis_tstrb = '1;

    // Handshake and bank bookkeeping terms shared by both sides.
    assign wr_fire_c     = s00_axis_tvalid & s00_axis_tready;
    assign wr_last_c     = (wr_cnt == CNT_W'(N_PIX - 1));
    assign wr_done_c     = wr_fire_c & wr_last_c;
    assign out_ld_c      = (state != IDLE) && (!m00_axis_tvalid || m00_axis_tready);
    assign k_last_c      = (k == K_W'(N_WORDS - 1));
    // Bank is released once its last B word is copied into the output register.
    assign rd_free_c     = out_ld_c && (state == PLANE_B) && k_last_c;
    assign wr_bank_nxt_c = wr_bank ^ wr_done_c;

    // Next full flags: write completion and read release never hit the same bank.
    always_comb begin
        full_nxt_c = full;
        for (int unsigned b = 0; b < 2; b++) begin
            full_nxt_c[b] = (full[b] | (wr_done_c && (wr_bank == 1'(b))))
                          & ~(rd_free_c && (rd_bank == 1'(b)));
        end
    end

    // Gather one channel of four consecutive pixels from the read bank.
    always_comb begin
        logic [PX_W-1:0] px;
        logic [7:0]      chan;
        rd_word_c = '0;
        px        = '0;
        chan      = '0;
        for (int unsigned n = 0; n < PX_PER_WORD; n++) begin
            px = mem[rd_bank][CNT_W'(32'(k) * PX_PER_WORD + n)];
            case (state)
                PLANE_G: chan = px[15:8];
                PLANE_B: chan = px[23:16];
                default: chan = px[7:0];
            endcase
            rd_word_c[8*n +: 8] = chan;
        end
    end

    // Pixel store; a bank is only written while its full flag is clear.
    always_ff @(posedge axis_aclk) begin
        if (wr_fire_c) begin
            mem[wr_bank][wr_cnt] <= s00_axis_tdata[PX_W-1:0];
        end
    end

    // Write side: fill pointer, bank flags, input ready and framing check.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            full            <= '0;
            wr_bank         <= 1'b0;
            rd_bank         <= 1'b0;
            wr_cnt          <= '0;
            s00_axis_tready <= 1'b0;
            tlast_err       <= 1'b0;
        end else begin
            full            <= full_nxt_c;
            wr_bank         <= wr_bank_nxt_c;
            rd_bank         <= rd_bank ^ rd_free_c;
            s00_axis_tready <= ~full_nxt_c[wr_bank_nxt_c];
            tlast_err       <= wr_fire_c & (s00_axis_tlast ^ wr_last_c);
            if (wr_fire_c) begin
                wr_cnt <= wr_last_c ? '0 : wr_cnt + 1'b1;
            end
        end
    end

    // Read FSM walking R, G, B planes and the registered output stage.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state           <= IDLE;
            k               <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state <= PLANE_R;
                        k     <= '0;
                    end
                end
                default: begin
                    if (out_ld_c) begin
                        k <= k + 1'b1;
                        if (k_last_c) begin
                            case (state)
                                PLANE_R: state <= PLANE_G;
                                PLANE_G: state <= PLANE_B;
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase

            if (out_ld_c) begin
                m00_axis_tvalid <= 1'b1;
                m00_axis_tdata  <= rd_word_c;
                m00_axis_tlast  <= k_last_c;
            end else if (m00_axis_tready) begin
                m00_axis_tvalid <= 1'b0;
                m00_axis_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_block_planarizer.sv
// Directed bench for rgb_block_planarizer: golden planar words per block,
// output stability under stalls, framing-error pulses and mid-block reset.
module tb_rgb_block_planarizer;

    logic        axis_aclk = 1'b0;
    logic        axis_areset;
    logic [31:0] s00_axis_tdata;
    logic        s00_axis_tvalid;
    logic        s00_axis_tready;
    logic        s00_axis_tlast;
    logic [31:0] m00_axis_tdata;
    logic [3:0]  m00_axis_tstrb;
    logic        m00_axis_tvalid;
    logic        m00_axis_tready;
    logic        m00_axis_tlast;
    logic        tlast_err;

    rgb_block_planarizer dut (
        .axis_aclk       (axis_aclk),
        .axis_areset     (axis_areset),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tready (s00_axis_tready),
        .s00_axis_tlast  (s00_axis_tlast),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tstrb  (m00_axis_tstrb),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready),
        .m00_axis_tlast  (m00_axis_tlast),
        .tlast_err       (tlast_err)
    );

    always #5 axis_aclk = ~axis_aclk;

    int          n_vec        = 0;
    int          n_miss       = 0;
    int          n_words      = 0;
    int          n_lasts      = 0;
    int          n_err_pulses = 0;
    int          stall_in     = 0;
    bit          mon_en       = 1'b0;
    bit          stop_rand    = 1'b0;
    logic [32:0] exp_q[$];
    logic [31:0] out_log [1024];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Seed 0 is the hand-checked gradient block; other seeds are arbitrary patterns.
    function automatic logic [23:0] gen_px(input int seed, input int i);
        logic [7:0] r, g, b;
        if (seed == 0) begin
            r = 8'((i % 8) * 30 + 10);
            g = 8'((i / 8) * 30 + 10);
            b = 8'(((i % 8) + (i / 8)) * 15 + 10);
        end else begin
            r = 8'(i * 7 + seed * 31);
            g = 8'(i * 3 + seed * 5 + 1);
            b = 8'(255 - i - seed * 11);
        end
        return {b, g, r};
    endfunction

    task automatic push_block(input int seed);
        logic [31:0] w;
        logic [23:0] px;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 16; k++) begin
                w = '0;
                for (int n = 0; n < 4; n++) begin
                    px = gen_px(seed, 4 * k + n);
                    w[8*n +: 8] = (p == 0) ? px[7:0] : (p == 1) ? px[15:8] : px[23:16];
                end
                exp_q.push_back({(k == 15), w});
            end
        end
    endtask

    task automatic send_block(input int seed, input int npix, input bit bad_tlast);
        logic tl;
        int   waited;
        for (int i = 0; i < npix; i++) begin
            tl = bad_tlast ? (i == 10) : (i == 63);
            s00_axis_tdata  = {8'hA5 ^ 8'(i), gen_px(seed, i)};
            s00_axis_tvalid = 1'b1;
            s00_axis_tlast  = tl;
            waited = 0;
            @(negedge axis_aclk);
            while (!s00_axis_tready && waited < 2000) begin
                waited++;
                stall_in++;
                @(negedge axis_aclk);
            end
            if (waited >= 2000) begin
                check("in_accept_timeout", 64'(s00_axis_tready), 64'(1));
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
                $fatal(1, "input stuck");
            end
            @(posedge axis_aclk);
            #1;
            check("tlast_err", 64'(tlast_err), 64'(tl ^ (i == 63)));
        end
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || m00_axis_tvalid) && c < budget) begin
            @(posedge axis_aclk);
            #1;
            c++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'(0));
        check("drain_tvalid", 64'(m00_axis_tvalid), 64'(0));
    endtask

    // Output monitor: sampled mid-cycle, a valid&ready here is the next edge's transfer.
    initial begin
        bit          stall_prev = 1'b0;
        logic        hold_last  = 1'b0;
        logic [31:0] hold_data  = '0;
        logic [32:0] e;
        forever begin
            @(negedge axis_aclk);
            if (mon_en) begin
                if (stall_prev) begin
                    check("stall_hold", 64'({m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata}),
                          64'({1'b1, hold_last, hold_data}));
                end
                if (m00_axis_tvalid && m00_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 64'(m00_axis_tvalid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", 64'(m00_axis_tdata), 64'(e[31:0]));
                        check("word_last", 64'(m00_axis_tlast), 64'(e[32]));
                    end
                    if (n_words < 1024) out_log[n_words] = m00_axis_tdata;
                    n_words++;
                    if (m00_axis_tlast) n_lasts++;
                end
                if (tlast_err) n_err_pulses++;
                stall_prev = m00_axis_tvalid && !m00_axis_tready;
                hold_last  = m00_axis_tlast;
                hold_data  = m00_axis_tdata;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d words seen", n_words);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int pulses0;

        axis_areset     = 1'b1;
        s00_axis_tdata  = '0;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        m00_axis_tready = 1'b0;

        // Reset values.
        repeat (3) @(posedge axis_aclk);
        #1;
        check("rst_s_tready", 64'(s00_axis_tready), 64'(0));
        check("rst_m_tvalid", 64'(m00_axis_tvalid), 64'(0));
        check("rst_m_tlast", 64'(m00_axis_tlast), 64'(0));
        check("rst_m_tdata", 64'(m00_axis_tdata), 64'(0));
        check("rst_tlast_err", 64'(tlast_err), 64'(0));
        check("tstrb", 64'(m00_axis_tstrb), 64'(4'hF));
        axis_areset = 1'b0;
        @(posedge axis_aclk);
        #1;
        check("post_rst_s_tready", 64'(s00_axis_tready), 64'(1));
        mon_en          = 1'b1;
        m00_axis_tready = 1'b1;

        // Single gradient block, latency and hand-computed words.
        push_block(0);
        send_block(0, 64, 1'b0);
        s00_axis_tvalid = 1'b0;
        check("lat_edge0", 64'(m00_axis_tvalid), 64'(0));
        @(posedge axis_aclk);
        #1;
        check("lat_edge1", 64'(m00_axis_tvalid), 64'(0));
        @(posedge axis_aclk);
        #1;
        check("lat_edge2", 64'(m00_axis_tvalid), 64'(1));
        check("lat_edge2_data", 64'(m00_axis_tdata), 64'(32'h6446280A));
        wait_drain(500);
        check("blk0_words", 64'(n_words), 64'(48));
        check("blk0_lasts", 64'(n_lasts), 64'(3));
        check("r_word0", 64'(out_log[0]), 64'(32'h6446280A));
        check("r_word15", 64'(out_log[15]), 64'(32'hDCBEA082));
        check("g_word0", 64'(out_log[16]), 64'(32'h0A0A0A0A));
        check("b_word0", 64'(out_log[32]), 64'(32'h3728190A));

        // Three back-to-back blocks, no output stalls.
        base     = n_words;
        stall_in = 0;
        push_block(1);
        push_block(2);
        push_block(3);
        send_block(1, 64, 1'b0);
        send_block(2, 64, 1'b0);
        send_block(3, 64, 1'b0);
        s00_axis_tvalid = 1'b0;
        wait_drain(500);
        check("b2b_in_stalls", 64'(stall_in), 64'(0));
        check("b2b_words", 64'(n_words - base), 64'(144));

        // Both banks fill behind a stalled output, then random backpressure.
        base            = n_words;
        m00_axis_tready = 1'b0;
        push_block(8);
        push_block(9);
        send_block(8, 64, 1'b0);
        send_block(9, 64, 1'b0);
        s00_axis_tdata  = {8'hA5, gen_px(10, 0)};
        s00_axis_tvalid = 1'b1;
        s00_axis_tlast  = 1'b0;
        @(negedge axis_aclk);
        check("both_full_tready", 64'(s00_axis_tready), 64'(0));
        @(negedge axis_aclk);
        check("both_full_tready_hold", 64'(s00_axis_tready), 64'(0));
        check("stalled_tvalid", 64'(m00_axis_tvalid), 64'(1));
        push_block(10);
        stop_rand = 1'b0;
        fork
            begin
                send_block(10, 64, 1'b0);
                s00_axis_tvalid = 1'b0;
                wait_drain(3000);
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge axis_aclk);
                    #1;
                    m00_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m00_axis_tready = 1'b1;
        check("stall_words", 64'(n_words - base), 64'(144));

        // tlast on pixel 10 and missing on pixel 63.
        base    = n_words;
        pulses0 = n_err_pulses;
        push_block(7);
        send_block(7, 64, 1'b1);
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        wait_drain(500);
        check("err_pulses", 64'(n_err_pulses - pulses0), 64'(2));
        check("err_blk_words", 64'(n_words - base), 64'(48));

        // Reset while one block drains (G plane) and the next is partly written.
        push_block(4);
        send_block(4, 64, 1'b0);
        send_block(5, 30, 1'b0);
        axis_areset     = 1'b1;
        s00_axis_tvalid = 1'b0;
        mon_en          = 1'b0;
        exp_q.delete();
        @(posedge axis_aclk);
        #1;
        check("midrst_m_tvalid", 64'(m00_axis_tvalid), 64'(0));
        check("midrst_s_tready", 64'(s00_axis_tready), 64'(0));
        check("midrst_m_tdata", 64'(m00_axis_tdata), 64'(0));
        @(posedge axis_aclk);
        #1;
        axis_areset = 1'b0;
        @(posedge axis_aclk);
        #1;
        check("after_rst_m_tvalid", 64'(m00_axis_tvalid), 64'(0));
        check("after_rst_s_tready", 64'(s00_axis_tready), 64'(1));
        mon_en = 1'b1;
        base   = n_words;
        repeat (6) begin
            @(posedge axis_aclk);
            #1;
            check("no_stale_tvalid", 64'(m00_axis_tvalid), 64'(0));
        end
        push_block(6);
        send_block(6, 64, 1'b0);
        s00_axis_tvalid = 1'b0;
        wait_drain(500);
        check("fresh_blk_words", 64'(n_words - base), 64'(48));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
